// File: rtl/uoram_request_scheduler_pkg.sv
// Shared definitions for the unified ORAM request scheduler.
// Holds the backend command encodings and the scheduler state encoding
// used by uoram_request_scheduler and its arbiter.
package uoram_request_scheduler_pkg;

  localparam int BECMD_Update  = 0;
  localparam int BECMD_Append  = 1;
  localparam int BECMD_Read    = 2;
  localparam int BECMD_ReadRmv = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_XFER   = 2'd3
  } schedState_t;

endpackage

// File: rtl/uoram_sched_arbiter.sv
// Two-way priority arbiter between LLC and PLB requesters.
// PLB normally wins a tie; after StarveLimit consecutive PLB grants taken
// while the LLC was waiting, the LLC wins the next tie.
// Ports:
//   Clock, Reset      clock, synchronous active-low reset
//   Enable            grants may only be issued while high (scheduler idle)
//   LLCValid/PLBValid request valids
//   LLCGrant/PLBGrant combinational one-hot grants
module uoram_sched_arbiter #(
  parameter int StarveLimit = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic LLCValid,
  input  logic PLBValid,
  output logic LLCGrant,
  output logic PLBGrant
);

  localparam int StarveW = $clog2(StarveLimit + 1);

  logic [StarveW-1:0] starveCnt;
  logic               llcFirst;

  always_comb begin
    llcFirst = (starveCnt == StarveW'(StarveLimit));
    LLCGrant = Enable && LLCValid && (!PLBValid || llcFirst);
    PLBGrant = Enable && PLBValid && !(LLCValid && llcFirst);
  end

  // The count cannot pass StarveLimit: at the limit a waiting LLC always wins.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      starveCnt <= '0;
    end else if (LLCGrant) begin
      starveCnt <= '0;
    end else if (PLBGrant && LLCValid) begin
      starveCnt <= starveCnt + StarveW'(1);
    end
  end

endmodule

// File: rtl/uoram_request_scheduler.sv
// Front-end request scheduler for the unified ORAM datapath.
// Grants one LLC or PLB request at a time, pulses the datapath switch,
// issues the backend command and then counts store/read beats until the
// block transfer completes.
// Ports:
//   Clock, Reset                  clock, synchronous active-low reset
//   LLCCmd*/LLCPAddr/LLCLeaf/LLCDumb  LLC request channel
//   PLBCmd*/PLBPAddr/PLBLeaf      PLB request channel (Read=refill, Update=evict)
//   SwitchReq/DataBlockReq/Cmd/DumbRequest  one-cycle datapath switch
//   BECmd*/BEPAddr/BELeaf         backend command channel
//   StoreBeat/LoadBeat/ReturnBeat accepted data beats
//   Busy, GrantIsData             status
// Optional: define UORAM_SCHED_WATCHDOG_EN to add ErrTimeout, a sticky
// timeout flag raised after WatchdogCycles idle cycles in ISSUE/XFER.
module uoram_request_scheduler
  import uoram_request_scheduler_pkg::*;
#(
  parameter int BECMDWidth     = 2,
  parameter int ORAMUWidth     = 32,
  parameter int LeafWidth      = 32,
  parameter int FEORAMBChunks  = 8,
  parameter int StarveLimit    = 4,
  parameter int WatchdogCycles = 4096
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  LLCCmdValid,
  output logic                  LLCCmdReady,
  input  logic [BECMDWidth-1:0] LLCCmd,
  input  logic [ORAMUWidth-1:0] LLCPAddr,
  input  logic [LeafWidth-1:0]  LLCLeaf,
  input  logic                  LLCDumb,
  input  logic                  PLBCmdValid,
  output logic                  PLBCmdReady,
  input  logic [BECMDWidth-1:0] PLBCmd,
  input  logic [ORAMUWidth-1:0] PLBPAddr,
  input  logic [LeafWidth-1:0]  PLBLeaf,
  output logic                  SwitchReq,
  output logic                  DataBlockReq,
  output logic [BECMDWidth-1:0] Cmd,
  output logic                  DumbRequest,
  output logic                  BECmdValid,
  input  logic                  BECmdReady,
  output logic [BECMDWidth-1:0] BECmd,
  output logic [ORAMUWidth-1:0] BEPAddr,
  output logic [LeafWidth-1:0]  BELeaf,
  input  logic                  StoreBeat,
  input  logic                  LoadBeat,
  input  logic                  ReturnBeat,
  output logic                  Busy,
  output logic                  GrantIsData
`ifdef UORAM_SCHED_WATCHDOG_EN
  ,
  output logic                  ErrTimeout
`endif
);

  localparam int CntW = $clog2(FEORAMBChunks + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FEORAMBChunks);

  schedState_t           state, stateNext;
  logic [BECMDWidth-1:0] cmdQ;
  logic [ORAMUWidth-1:0] addrQ;
  logic [LeafWidth-1:0]  leafQ;
  logic                  dumbQ, isDataQ;
  logic [CntW-1:0]       stCnt, rdCnt, stCntNext, rdCntNext;
  logic                  grantLLC, grantPLB, idle, cmdIsRead;
  logic                  stReq, rdReq, rdBeat, done, timeout;

  assign idle = (state == ST_IDLE);

  uoram_sched_arbiter #(
    .StarveLimit(StarveLimit)
  ) arbiter (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (idle && Reset),
    .LLCValid(LLCCmdValid),
    .PLBValid(PLBCmdValid),
    .LLCGrant(grantLLC),
    .PLBGrant(grantPLB)
  );

  assign LLCCmdReady = grantLLC;
  assign PLBCmdReady = grantPLB;

  // Required beats per request type; a dumb LLC read still moves a full
  // block in both directions.
  always_comb begin
    cmdIsRead = (cmdQ == BECMDWidth'(BECMD_Read)) || (cmdQ == BECMDWidth'(BECMD_ReadRmv));
    if (isDataQ) begin
      stReq  = !cmdIsRead || dumbQ;
      rdReq  = cmdIsRead;
      rdBeat = ReturnBeat;
    end else begin
      stReq  = (cmdQ == BECMDWidth'(BECMD_Update));
      rdReq  = (cmdQ == BECMDWidth'(BECMD_Read));
      rdBeat = LoadBeat;
    end
  end

  // Counting looks at this cycle's beat so completion is seen on the final
  // beat itself and IDLE follows one cycle later.
  always_comb begin
    stCntNext = stCnt;
    rdCntNext = rdCnt;
    if (!idle && StoreBeat && (stCnt != CntFull)) stCntNext = stCnt + CntW'(1);
    if (!idle && rdBeat && (rdCnt != CntFull))    rdCntNext = rdCnt + CntW'(1);
    done = (!stReq || (stCntNext == CntFull)) && (!rdReq || (rdCntNext == CntFull));
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:   if (grantLLC || grantPLB) stateNext = ST_SWITCH;
      ST_SWITCH: stateNext = ST_ISSUE;
      ST_ISSUE:  if (BECmdReady) stateNext = done ? ST_IDLE : ST_XFER;
      ST_XFER:   if (done) stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
    if (timeout) stateNext = ST_IDLE;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= ST_IDLE;
      isDataQ <= 1'b0;
      stCnt   <= '0;
      rdCnt   <= '0;
    end else begin
      state <= stateNext;
      if (grantLLC || grantPLB) isDataQ <= grantLLC;
      stCnt <= (stateNext == ST_IDLE) ? '0 : stCntNext;
      rdCnt <= (stateNext == ST_IDLE) ? '0 : rdCntNext;
    end
  end

  // Request payload is only observed through state-gated outputs, so it
  // needs no reset.
  always_ff @(posedge Clock) begin
    if (grantLLC || grantPLB) begin
      cmdQ  <= grantLLC ? LLCCmd   : PLBCmd;
      addrQ <= grantLLC ? LLCPAddr : PLBPAddr;
      leafQ <= grantLLC ? LLCLeaf  : PLBLeaf;
      dumbQ <= grantLLC && LLCDumb;
    end
  end

  assign SwitchReq    = (state == ST_SWITCH);
  assign DataBlockReq = SwitchReq && isDataQ;
  assign Cmd          = SwitchReq ? cmdQ : '0;
  assign DumbRequest  = SwitchReq && dumbQ;
  assign BECmdValid   = (state == ST_ISSUE);
  assign BECmd        = BECmdValid ? cmdQ  : '0;
  assign BEPAddr      = BECmdValid ? addrQ : '0;
  assign BELeaf       = BECmdValid ? leafQ : '0;
  assign Busy         = !idle;
  assign GrantIsData  = isDataQ;

`ifdef UORAM_SCHED_WATCHDOG_EN
  localparam int WdW = $clog2(WatchdogCycles + 1);

  logic [WdW-1:0] wdCnt;
  logic           errQ, activity, waiting;

  assign waiting  = (state == ST_ISSUE) || (state == ST_XFER);
  assign activity = StoreBeat || LoadBeat || ReturnBeat || (BECmdValid && BECmdReady);
  assign timeout  = waiting && !activity && (wdCnt == WdW'(WatchdogCycles - 1));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wdCnt <= '0;
      errQ  <= 1'b0;
    end else begin
      if (timeout) errQ <= 1'b1;
      if (!waiting || activity || timeout) wdCnt <= '0;
      else                                 wdCnt <= wdCnt + WdW'(1);
    end
  end

  assign ErrTimeout = errQ;
`else
  // No watchdog in this build: the scheduler waits indefinitely.
  assign timeout = (WatchdogCycles < 0);
`endif

endmodule

// File: doc/uoram_request_scheduler.md
Name: uoram_request_scheduler

Overview:
- Front-end scheduler for the unified ORAM datapath.
- Arbitrates between LLC data-block requests and PLB PosMap requests (refill read / evict update).
- Sequences the datapath: switch pulse, then backend command, then beat accounting until the block transfer completes.
- Exactly one request is in flight at a time; the datapath's Expecting* state is only switched while the scheduler is idle-bound.

Parameters:
- BECMDWidth, 2, backend command width
- ORAMUWidth, 32, program address width
- LeafWidth, 32, leaf label width
- FEORAMBChunks, 8, FEDWidth beats per block (>=2)
- StarveLimit, 4, max consecutive PLB grants while an LLC request waits (>=1)
- WatchdogCycles, 4096, XFER timeout (feature only)

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-low reset (0 = reset)
- LLCCmdValid / LLCCmdReady  in/out  1/1  LLC request handshake
- LLCCmd  in  BECMDWidth  LLC command
- LLCPAddr  in  ORAMUWidth  LLC block address
- LLCLeaf  in  LeafWidth  LLC leaf
- LLCDumb  in  1  request targets a non-existent block
- PLBCmdValid / PLBCmdReady  in/out  1/1  PLB request handshake
- PLBCmd  in  BECMDWidth  PLB command: Read = refill, Update = evict
- PLBPAddr  in  ORAMUWidth  PLB address
- PLBLeaf  in  LeafWidth  PLB leaf
- SwitchReq  out  1  one-cycle datapath switch pulse
- DataBlockReq  out  1  valid with SwitchReq
- Cmd  out  BECMDWidth  valid with SwitchReq
- DumbRequest  out  1  valid with SwitchReq
- BECmdValid / BECmdReady  out/in  1/1  backend command handshake
- BECmd  out  BECMDWidth  backend command
- BEPAddr  out  ORAMUWidth  backend address
- BELeaf  out  LeafWidth  backend leaf
- StoreBeat  in  1  StoreDataValid && StoreDataReady
- LoadBeat  in  1  backend->PLB refill beat accepted
- ReturnBeat  in  1  ReturnDataValid && ReturnDataReady
- Busy  out  1  state != IDLE
- GrantIsData  out  1  current/last grant was LLC

Behaviour:
- Reset (Reset == 0 at a Clock edge):
  - State -> IDLE; counters and starve count cleared.
  - All outputs 0, including both Readys and BECmdValid.
  - Reset mid-operation abandons the request silently.
- IDLE:
  - Readys are combinational grants, asserted only in IDLE.
  - Priority: PLB wins if both valid, unless StarveCnt == StarveLimit, in which case LLC wins.
  - StarveCnt increments on a PLB grant while LLCCmdValid; clears on any LLC grant.
  - On grant: latch Cmd/PAddr/Leaf/Dumb (Dumb forced 0 for PLB), set GrantIsData, go to SWITCH.
- SWITCH (1 cycle):
  - SwitchReq = 1, with DataBlockReq = GrantIsData and Cmd/DumbRequest from the latches.
  - Next state ISSUE.
- ISSUE:
  - BECmdValid held with stable payload until BECmdReady; then go to XFER.
  - If the required beat counts are both 0, return straight to IDLE.
- XFER:
  - Separate counters StCnt and RdCnt (width log2(FEORAMBChunks+1)), saturating at FEORAMBChunks.
  - Beats arriving in SWITCH/ISSUE are counted as well.
  - Required counts:
    - LLC Append/Update: St = N, Rd = 0
    - LLC Read/ReadRmv: St = 0, Rd = N (ReturnBeat)
    - LLC Read/ReadRmv with Dumb: St = N, Rd = N (ReturnBeat)
    - PLB Read: St = 0, Rd = N (LoadBeat)
    - PLB Update: St = N, Rd = 0
  - For PLB grants RdCnt counts LoadBeat; for LLC grants it counts ReturnBeat.
  - When both counts are met: IDLE next cycle, counters cleared. The earliest next SwitchReq is 2 cycles after the final beat.
- Beats in IDLE are ignored. A beat beyond the required count is ignored (saturation).

Optional Feature:
- UORAM_SCHED_WATCHDOG_EN defined:
  - Adds output ErrTimeout (1).
  - A cycle counter runs in ISSUE+XFER and clears on any beat or handshake.
  - Reaching WatchdogCycles sets ErrTimeout sticky until reset and forces IDLE.
- Undefined: no port and no counter; the block waits indefinitely.

Decomposition:
- Shared package UORAMSched.vh: BECMD_Update=0, BECMD_Append=1, BECMD_Read=2, BECMD_ReadRmv=3; state encodings IDLE/SWITCH/ISSUE/XFER.
- One sub-module: uoram_sched_arbiter (2-way priority with starvation counter, combinational grant + StarveCnt register).

Test Plan:
- PLB Read only (PAddr 0x10, Leaf 0x5) -> SwitchReq with DataBlockReq=0; BECmd=2 held under 3 stall cycles; 8 LoadBeats -> Busy falls 1 cycle after the 8th.
- LLC Append (PAddr 0x20) -> DataBlockReq=1, Cmd=1; 8 StoreBeats complete; 4 spurious ReturnBeats are ignored and do not end XFER early.
- LLC Read with LLCDumb=1 -> DumbRequest=1; ends only after 8 StoreBeats and 8 ReturnBeats, interleaved arbitrarily.
- LLC and PLB both always valid, StarveLimit=4 -> grant sequence P,P,P,P,L,P,P,P,P,L.
- Reset low during XFER after 3 beats -> next cycle all outputs 0, Busy=0; a new request then needs a full 8 beats.
- With UORAM_SCHED_WATCHDOG_EN and WatchdogCycles=16, issue PLB Read with no beats -> ErrTimeout=1 at cycle 16, state IDLE, ErrTimeout stays 1.
